// File: rtl/signal_ramper_multi.sv
// Phase-synchronous amplitude ramper: ramps up over 2^L_up DDS periods, holds full scale,
// ramps down over 2^L_dn periods on request, then parks at zero until re-armed.
module signal_ramper_multi #(
  parameter int unsigned PHASE_WIDTH  = 48,
  parameter int unsigned RAMP_BITS    = 13,
  parameter int unsigned MAX_LEN_LOG2 = 4,
  parameter int unsigned OUT_WIDTH    = 16,
  localparam int unsigned LEN_W       = $clog2(MAX_LEN_LOG2 + 1)
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [PHASE_WIDTH-1:0] s_axis_tdata_phase,
  input  logic                   s_axis_tvalid_phase,
  input  logic                   enableRamping,
  input  logic [LEN_W-1:0]       rampUpLenLog2,
  input  logic [LEN_W-1:0]       rampDownLenLog2,
  input  logic                   startRampDown,
  input  logic                   startRampUp,
  output logic [OUT_WIDTH-1:0]   ramp,
  output logic [1:0]             rampState,
  output logic                   rampPending
);

  localparam int unsigned CNT_W = MAX_LEN_LOG2;
  localparam int unsigned SPN_W = MAX_LEN_LOG2 + 1;
  localparam int unsigned PRG_W = MAX_LEN_LOG2 + RAMP_BITS;
  localparam logic [RAMP_BITS-1:0] FS = '1;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_DONE   = 2'b01,
    ST_UP     = 2'b10,
    ST_DOWN   = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RAMP_BITS-1:0]   phase_top_q, phase_prev_q;
  logic                   valid_q;
  logic                   pend_q, pend_d;
  logic [LEN_W-1:0]       l_up_q, l_up_d, l_dn_q, l_dn_d;
  logic                   fresh_q;
  logic [OUT_WIDTH-1:0]   ramp_q, ramp_d;

  logic [LEN_W-1:0]       up_clamp, dn_clamp, l_sel;
  logic                   wrap, cnt_last;
  logic [SPN_W-1:0]       len_span;
  logic [CNT_W-1:0]       cnt_eff;
  logic [PRG_W-1:0]       prog_full;
  logic [RAMP_BITS-1:0]   progress, ramp_val;
  logic                   unused_phase_lsbs;

  assign unused_phase_lsbs = ^s_axis_tdata_phase[PHASE_WIDTH-RAMP_BITS-1:0];

  // Progress datapath; on a wrap the count is advanced so the new period starts at its own level
  always_comb begin
    up_clamp  = (rampUpLenLog2 > LEN_W'(MAX_LEN_LOG2)) ? LEN_W'(MAX_LEN_LOG2) : rampUpLenLog2;
    dn_clamp  = (rampDownLenLog2 > LEN_W'(MAX_LEN_LOG2)) ? LEN_W'(MAX_LEN_LOG2) : rampDownLenLog2;
    wrap      = valid_q && (phase_top_q < phase_prev_q);
    l_sel     = (state_q == ST_DOWN) ? l_dn_q : l_up_q;
    len_span  = SPN_W'(1) << l_sel;
    cnt_last  = (cnt_q == CNT_W'(len_span - SPN_W'(1)));
    cnt_eff   = wrap ? (cnt_q + CNT_W'(1)) : cnt_q;
    prog_full = {cnt_eff, phase_top_q} >> l_sel;
    progress  = RAMP_BITS'(prog_full);
  end

  // Next-state and ramp value
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    l_up_d   = l_up_q;
    l_dn_d   = l_dn_q;
    ramp_val = FS;
    case (state_q)
      ST_UP: begin
        ramp_val = progress;
        if (startRampDown) pend_d = 1'b1;
        if (wrap) begin
          if (cnt_last) begin
            state_d  = ST_NORMAL;
            ramp_val = FS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_NORMAL: begin
        ramp_val = FS;
        if (startRampDown || pend_q) state_d = ST_DOWN;
      end
      ST_DOWN: begin
        ramp_val = FS - progress;
        if (wrap) begin
          if (cnt_last) begin
            state_d  = ST_DONE;
            ramp_val = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        ramp_val = '0;
        if (startRampUp) state_d = ST_UP;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == ST_UP) l_up_d = up_clamp;
      if (state_d == ST_DOWN) begin
        l_dn_d = dn_clamp;
        pend_d = 1'b0;
      end
    end
    // Lengths are taken from the live inputs on the first edge after reset release
    if (fresh_q) begin
      l_up_d = up_clamp;
      l_dn_d = dn_clamp;
    end
    ramp_d = enableRamping ? OUT_WIDTH'(ramp_val) : OUT_WIDTH'(FS);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_UP;
      cnt_q        <= '0;
      phase_top_q  <= '0;
      phase_prev_q <= '0;
      valid_q      <= 1'b0;
      pend_q       <= 1'b0;
      l_up_q       <= LEN_W'(MAX_LEN_LOG2);
      l_dn_q       <= LEN_W'(MAX_LEN_LOG2);
      fresh_q      <= 1'b1;
      ramp_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= s_axis_tvalid_phase;
      if (s_axis_tvalid_phase) begin
        phase_top_q  <= s_axis_tdata_phase[PHASE_WIDTH-1 -: RAMP_BITS];
        phase_prev_q <= phase_top_q;
      end
      pend_q  <= pend_d;
      l_up_q  <= l_up_d;
      l_dn_q  <= l_dn_d;
      fresh_q <= 1'b0;
      ramp_q  <= ramp_d;
    end
  end

  assign ramp        = ramp_q;
  assign rampState   = state_q;
  assign rampPending = pend_q;

endmodule

// File: tb/tb_signal_ramper_multi.sv
// Directed bench for signal_ramper_multi with hand-computed ramp/state values.
module tb_signal_ramper_multi;

  localparam int unsigned PW = 48;
  localparam int unsigned ST_NORMAL = 0, ST_DONE = 1, ST_UP = 2, ST_DOWN = 3;

  logic          clk = 1'b0;
  logic          areset;
  logic [PW-1:0] phase;
  logic          valid;
  logic          en;
  logic [2:0]    up_len, dn_len;
  logic          srd, sru;
  logic [15:0]   ramp;
  logic [1:0]    rstate;
  logic          pend;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  signal_ramper_multi dut (
    .clk                 (clk),
    .areset              (areset),
    .s_axis_tdata_phase  (phase),
    .s_axis_tvalid_phase (valid),
    .enableRamping       (en),
    .rampUpLenLog2       (up_len),
    .rampDownLenLog2     (dn_len),
    .startRampDown       (srd),
    .startRampUp         (sru),
    .ramp                (ramp),
    .rampState           (rstate),
    .rampPending         (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned top, input logic v);
    phase = {13'(top), 35'd0};
    valid = v;
    @(posedge clk);
    #1;
  endtask

  // One valid sample then one idle cycle, so outputs reflect that sample on return
  task automatic push(input int unsigned top);
    tick(top, 1'b1);
    tick(top, 1'b0);
  endtask

  initial begin
    areset = 1'b1; phase = '0; valid = 1'b0; en = 1'b1;
    up_len = 3'd0; dn_len = 3'd0; srd = 1'b0; sru = 1'b0;
    #23;
    check("rst_ramp", ramp, 0);
    check("rst_state", rstate, ST_UP);
    check("rst_pend", pend, 0);
    @(posedge clk); #1 areset = 1'b0;

    // Single-period ramp-up
    push(0);    check("up0_a", ramp, 0);
    push(4096); check("up0_b", ramp, 4096);
    push(8191); check("up0_c", ramp, 8191);
    push(100);  check("up0_wrap_st", rstate, ST_NORMAL);
                check("up0_wrap_r", ramp, 8191);
    push(5000); check("norm_r", ramp, 8191);

    // Ramp-down over two periods
    dn_len = 3'd1;
    srd = 1'b1; tick(5000, 1'b0); srd = 1'b0;
    check("dn_enter", rstate, ST_DOWN);
    push(6000); check("dn_a", ramp, 5191);
    push(8191); check("dn_b", ramp, 4096);
    push(0);    check("dn_c", ramp, 4095);
                check("dn_c_st", rstate, ST_DOWN);
    push(4000); check("dn_d", ramp, 2095);
    push(50);   check("done_st", rstate, ST_DONE);
                check("done_r", ramp, 0);
    srd = 1'b1; tick(50, 1'b0); srd = 1'b0;
    check("done_ign_srd", rstate, ST_DONE);

    // Re-arm and ramp up over four periods, with a valid gap and bypass
    up_len = 3'd2;
    sru = 1'b1; tick(50, 1'b0); sru = 1'b0;
    check("rearm_st", rstate, ST_UP);
    check("rearm_r", ramp, 0);
    push(100);  check("up2_a", ramp, 25);
    push(8000); check("up2_b", ramp, 2000);
    push(0);    check("up2_p1", ramp, 2048);
    push(8191); check("up2_c", ramp, 4095);
    push(0);    check("up2_p2", ramp, 4096);
    push(4000); check("up2_d", ramp, 5096);
    for (int i = 0; i < 10; i++) tick(0, 1'b0);
    check("gap_r", ramp, 5096);
    check("gap_st", rstate, ST_UP);
    en = 1'b0;
    push(4100); check("byp_r", ramp, 8191);
                check("byp_st", rstate, ST_UP);
    en = 1'b1;
    push(0);    check("up2_p3", ramp, 6144);
    push(8191); check("up2_e", ramp, 8191);
    push(10);   check("up2_norm", rstate, ST_NORMAL);
    sru = 1'b1; tick(10, 1'b0); sru = 1'b0;
    check("norm_ign_sru", rstate, ST_NORMAL);

    // Clamped ramp-down length, then reset mid-ramp
    dn_len = 3'd7;
    srd = 1'b1; tick(10, 1'b0); srd = 1'b0;
    check("dn4_enter", rstate, ST_DOWN);
    push(4000); check("dn4_clamp", ramp, 7941);
    areset = 1'b1; up_len = 3'd0;
    #2;
    check("mid_rst_r", ramp, 0);
    check("mid_rst_st", rstate, ST_UP);
    @(posedge clk); #1 areset = 1'b0;

    // Ramp-down request held off during ramp-up
    srd = 1'b1; push(3000); srd = 1'b0;
    check("pend_r", ramp, 3000);
    check("pend_set", pend, 1);
    push(8191);
    push(5);    check("pend_norm", rstate, ST_NORMAL);
                check("pend_hold", pend, 1);
    tick(5, 1'b0);
    check("pend_dn", rstate, ST_DOWN);
    check("pend_clr", pend, 0);
    en = 1'b0;
    push(4000); check("dn_byp", ramp, 8191);
    en = 1'b1;
    push(4000); check("dn_en", ramp, 7941);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_ramper_multi.md
SIGNAL_RAMPER_MULTI -- requirements
Module: signal_ramper_multi

Interface
REQ-001 Parameter PHASE_WIDTH, default 48, width of the DDS phase word.
REQ-002 Parameter RAMP_BITS, default 13, ramp resolution; full scale FS = 2^RAMP_BITS-1.
REQ-003 Parameter MAX_LEN_LOG2, default 4, maximum ramp length exponent; a ramp spans 2^len phase periods.
REQ-004 Parameter OUT_WIDTH, default 16, output width; RAMP_BITS SHALL be less than OUT_WIDTH.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 s_axis_tdata_phase  in  PHASE_WIDTH  DDS phase; top RAMP_BITS bits form phaseTop.
REQ-008 s_axis_tvalid_phase  in  1  phase sample valid.
REQ-009 enableRamping  in  1  1 = apply ramp, 0 = output FS.
REQ-010 rampUpLenLog2  in  ceil(log2(MAX_LEN_LOG2+1))  ramp-up length L_up; values > MAX_LEN_LOG2 clamp to MAX_LEN_LOG2.
REQ-011 rampDownLenLog2  in  same  ramp-down length L_dn; same clamp.
REQ-012 startRampDown  in  1  level request to ramp down.
REQ-013 startRampUp  in  1  level request to re-arm from DONE.
REQ-014 ramp  out  OUT_WIDTH  unsigned ramp factor, zero-extended.
REQ-015 rampState  out  2  UP=2'b10, NORMAL=2'b00, DOWN=2'b11, DONE=2'b01.
REQ-016 rampPending  out  1  ramp-down request latched but not yet acted on.

Function
REQ-017 phaseTop and phasePrev SHALL update only on cycles with s_axis_tvalid_phase=1; otherwise hold.
REQ-018 A wrap event SHALL be a valid cycle where new phaseTop < phasePrev (strict).
REQ-019 Period counter cnt (MAX_LEN_LOG2 bits) SHALL clear on every state entry and increment on each wrap within UP/DOWN.
REQ-020 L_up/L_dn SHALL be sampled into internal registers on entry to UP/DOWN respectively; changes mid-ramp have no effect.
REQ-021 Progress P = floor((cnt*2^RAMP_BITS + phaseTop) / 2^L), range 0..FS, computed by shift/concatenate only, no divider.
REQ-022 UP: rampValue = P; on wrap with cnt = 2^L_up-1 -> NORMAL.
REQ-023 NORMAL: rampValue = FS; startRampDown=1 or rampPending=1 -> DOWN next cycle.
REQ-024 DOWN: rampValue = FS - P; on wrap with cnt = 2^L_dn-1 -> DONE, and that cycle rampValue = 0.
REQ-025 DONE: rampValue = 0; startRampUp=1 -> UP next cycle; startRampDown ignored.
REQ-026 startRampDown asserted in UP SHALL set rampPending; rampPending clears on entry to DOWN.
REQ-027 startRampUp outside DONE SHALL be ignored.
REQ-028 ramp SHALL be registered: ramp = enableRamping ? rampValue : FS, one cycle after the state/phaseTop producing it.
REQ-029 Latency: valid phase sample at input to corresponding ramp output = 2 clk cycles.
REQ-030 enableRamping SHALL not affect state progression.
REQ-031 With L=0, behaviour SHALL equal a single-period ramp (P = phaseTop).

Reset
REQ-032 areset=1 SHALL asynchronously force state=UP, cnt=0, phaseTop=0, phasePrev=0, rampPending=0, ramp=0, L registers=MAX_LEN_LOG2 clamp of current input sampled on release.
REQ-033 After areset deasserts, the first valid sample SHALL not generate a wrap (phasePrev=0).
REQ-034 areset mid-DOWN or mid-UP SHALL abandon the ramp and restart at UP with cnt=0.

Verification
REQ-035 Defaults, L_up=0, phase sweeping 0..max then wrap -> ramp tracks phaseTop 0..8191, state UP->NORMAL on wrap, ramp=8191 thereafter.
REQ-036 L_up=2, phase 4 periods -> ramp rises 0..8191 linearly across 4 periods (period k starts at 2048*k), NORMAL after 4th wrap.
REQ-037 In NORMAL, pulse startRampDown one cycle, L_dn=1 -> DOWN, ramp falls 8191..0 over 2 periods, DONE with ramp=0 on final wrap.
REQ-038 startRampDown held during UP -> rampPending=1, NORMAL lasts exactly one cycle, then DOWN, rampPending=0.
REQ-039 tvalid deasserted for 10 cycles mid-UP -> ramp and cnt hold constant; enableRamping=0 -> ramp=8191 while rampState still sequences.
REQ-040 areset pulsed mid-DOWN -> ramp=0 immediately, state=UP; in DONE, startRampUp=1 -> UP next cycle, ramp restarts at 0.
